// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues one word read at a time and hands each
// fetched instruction to the decoder. Optional misaligned-PC trap: IFU_MISALIGN_TRAP_EN.
module ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        inst_fault
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [63:0] pc_reg, pc_next;
    logic        drop_reg, drop_next;
    logic [31:0] inst_reg, inst_next;
    logic [63:0] inst_pc_reg, inst_pc_next;
    logic        req_valid;

`ifdef IFU_MISALIGN_TRAP_EN
    logic        fault_reg, fault_next;
    logic        misaligned;

    assign misaligned = (pc_reg[1:0] != 2'b00);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= REQ;
            pc_reg      <= RESET_PC;
            drop_reg    <= 1'b0;
            inst_reg    <= 32'h0;
            inst_pc_reg <= 64'h0;
`ifdef IFU_MISALIGN_TRAP_EN
            fault_reg   <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            drop_reg    <= drop_next;
            inst_reg    <= inst_next;
            inst_pc_reg <= inst_pc_next;
`ifdef IFU_MISALIGN_TRAP_EN
            fault_reg   <= fault_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        drop_next    = drop_reg;
        inst_next    = inst_reg;
        inst_pc_next = inst_pc_reg;
        req_valid    = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
        fault_next   = fault_reg;
`endif
        unique case (state_reg)
            REQ: begin
`ifdef IFU_MISALIGN_TRAP_EN
                // A misaligned PC never reaches memory; it becomes a faulting bubble instead.
                if (misaligned) begin
                    if (redirect_valid) begin
                        pc_next = redirect_pc;
                    end else begin
                        state_next   = HOLD;
                        inst_next    = 32'h0;
                        inst_pc_next = pc_reg;
                        fault_next   = 1'b1;
                    end
                end else
`endif
                begin
                    req_valid = 1'b1;
                    if (redirect_valid) begin
                        pc_next = redirect_pc;
                        // The request accepted this cycle is for the old PC; its reply must be dropped.
                        if (imem_req_ready) begin
                            drop_next  = 1'b1;
                            state_next = WAIT;
                        end
                    end else if (imem_req_ready) begin
                        state_next = WAIT;
                    end
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                end
                if (imem_resp_valid) begin
                    drop_next = 1'b0;
                    if (!drop_reg && !redirect_valid) begin
                        state_next   = HOLD;
                        inst_next    = imem_resp_data;
                        inst_pc_next = pc_reg;
`ifdef IFU_MISALIGN_TRAP_EN
                        fault_next   = 1'b0;
`endif
                    end else begin
                        state_next = REQ;
                    end
                end else if (redirect_valid) begin
                    drop_next = 1'b1;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = REQ;
                end else if (inst_ready) begin
                    pc_next    = pc_reg + 64'd4;
                    state_next = REQ;
                end
            end

            default: begin
                state_next = REQ;
            end
        endcase
    end

    // The reset term keeps the request low while the state register is held in REQ.
    assign imem_req_valid = req_valid && !rst;
    assign imem_req_addr  = pc_reg;
    assign inst_valid     = (state_reg == HOLD);
    assign inst           = inst_reg;
    assign inst_pc        = inst_pc_reg;
`ifdef IFU_MISALIGN_TRAP_EN
    assign inst_fault     = fault_reg;
`else
    assign inst_fault     = 1'b0;
`endif

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed fetch/redirect scenarios followed by randomized traffic
// against an architectural PC model and a behavioural instruction memory.
module tb_ifu;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_fault;

    int n_checks = 0;
    int n_fail   = 0;

    // memory model state
    logic        pending = 1'b0;
    logic [63:0] pend_addr = 64'h0;
    int          pend_cnt = 0;
    logic        stray = 1'b0;

    // architectural model
    logic [63:0] m_pc = RESET_PC;
    logic        prev_hold = 1'b0;
    int          consumed = 0;
    int          idle = 0;

    // samples of the current cycle
    logic        s_req_valid, s_inst_valid, s_fault;
    logic [63:0] s_addr, s_inst_pc;
    logic [31:0] s_inst;

    ifu #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_0000) return 32'h0010_0073;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] exp_inst(input logic [63:0] a);
`ifdef IFU_MISALIGN_TRAP_EN
        if (a[1:0] != 2'b00) return 32'h0;
`endif
        return mem_word(a);
    endfunction

    function automatic logic exp_fault(input logic [63:0] a);
`ifdef IFU_MISALIGN_TRAP_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0 & a[0];
`endif
    endfunction

    // One clock period: drive inputs, sample, check against the model, advance the model.
    task automatic cycle(input logic rv, input logic [63:0] rpc, input logic ir,
                         input logic rr_in, input int lat);
        logic rr;
        logic rsp;
        rr = rr_in;
        @(negedge clk);
        rsp = 1'b0;
        if (stray) begin
            rsp = 1'b1;
            imem_resp_data = $urandom;
            rr = 1'b0;
            stray = 1'b0;
        end else if (pending) begin
            pend_cnt--;
            rsp = (pend_cnt == 0);
            imem_resp_data = mem_word(pend_addr);
        end
        imem_resp_valid = rsp;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        inst_ready      = ir;
        imem_req_ready  = rr;
        #1;
        s_req_valid  = imem_req_valid;
        s_addr       = imem_req_addr;
        s_inst_valid = inst_valid;
        s_inst       = inst;
        s_inst_pc    = inst_pc;
        s_fault      = inst_fault;

        if (s_req_valid) begin
            check("req_addr", s_addr, m_pc);
            check("req_while_busy", 64'(pending && !rsp), 64'h0);
            check("req_in_hold", 64'(s_inst_valid), 64'h0);
`ifdef IFU_MISALIGN_TRAP_EN
            check("req_misaligned", 64'(m_pc[1:0]), 64'h0);
`endif
        end
        if (s_inst_valid) begin
            check("inst_pc", s_inst_pc, m_pc);
            check("inst", 64'(s_inst), 64'(exp_inst(m_pc)));
            check("inst_fault", 64'(s_fault), 64'(exp_fault(m_pc)));
        end
        if (prev_hold) check("hold_valid", 64'(s_inst_valid), 64'h1);

        idle = (s_req_valid || s_inst_valid) ? 0 : idle + 1;
        if (idle > 20) begin
            check("stall_cycles", 64'(idle), 64'd20);
            idle = 0;
        end

        if (rsp) pending = 1'b0;
        if (s_req_valid && rr) begin
            pending   = 1'b1;
            pend_addr = s_addr;
            pend_cnt  = lat;
        end
        prev_hold = s_inst_valid && !ir && !rv;
        if (s_inst_valid && ir) consumed++;
        if (rv) m_pc = rpc;
        else if (s_inst_valid && ir) m_pc = m_pc + 64'd4;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 64'(imem_req_valid), 64'h0);
        check({tag, "_inst_valid"}, 64'(inst_valid), 64'h0);
        check({tag, "_inst"}, 64'(inst), 64'h0);
        check({tag, "_inst_pc"}, inst_pc, 64'h0);
        check({tag, "_inst_fault"}, 64'(inst_fault), 64'h0);
        check({tag, "_addr"}, imem_req_addr, RESET_PC);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        redirect_valid  = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        inst_ready      = 1'b0;
        #1 check_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        m_pc = RESET_PC;
        if (pending) stray = 1'b1;
        pending   = 1'b0;
        prev_hold = 1'b0;
        idle      = 0;
    endtask

    initial begin
        logic        rv, ir, rr;
        logic [63:0] rpc;
        int          k;
        bit          found;

        @(negedge clk);
        #1 check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // first fetch with a 1-cycle memory
        cycle(1'b0, 64'h0, 1'b1, 1'b1, 1);
        check("first_req_valid", 64'(s_req_valid), 64'h1);
        check("first_req_addr", s_addr, 64'h0000_0000_8000_0000);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1);
        check("wait_no_inst", 64'(s_inst_valid), 64'h0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1);
        check("first_inst_valid", 64'(s_inst_valid), 64'h1);
        check("first_inst", 64'(s_inst), 64'h0010_0073);
        check("first_inst_pc", s_inst_pc, 64'h0000_0000_8000_0000);
        cycle(1'b0, 64'h0, 1'b1, 1'b1, 1);
        check("second_req_addr", s_addr, 64'h0000_0000_8000_0004);

        // decoder stalls for 5 cycles in HOLD
        cycle(1'b0, 64'h0, 1'b0, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 64'h0, 1'b0, 1'b1, 1);
            check("stall_valid", 64'(s_inst_valid), 64'h1);
            check("stall_inst_pc", s_inst_pc, 64'h0000_0000_8000_0004);
            check("stall_inst", 64'(s_inst), 64'(mem_word(64'h0000_0000_8000_0004)));
            check("stall_no_req", 64'(s_req_valid), 64'h0);
        end
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1);
        cycle(1'b0, 64'h0, 1'b0, 1'b1, 3);
        check("after_stall_addr", s_addr, 64'h0000_0000_8000_0008);

        // redirect while waiting on a 3-cycle memory
        cycle(1'b1, 64'h0000_0000_8000_0100, 1'b1, 1'b0, 1);
        check("wait_redirect_no_inst", 64'(s_inst_valid), 64'h0);
        found = 1'b0;
        for (k = 0; k < 6 && !found; k++) begin
            cycle(1'b0, 64'h0, 1'b1, 1'b0, 1);
            found = s_req_valid;
            if (!found) check("stale_not_presented", 64'(s_inst_valid), 64'h0);
        end
        check("redirect_req_seen", 64'(found), 64'h1);
        check("redirect_req_addr", s_addr, 64'h0000_0000_8000_0100);

        // redirect in HOLD with consume the same cycle
        cycle(1'b0, 64'h0, 1'b1, 1'b1, 1);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1);
        cycle(1'b1, 64'h0000_0000_8000_0200, 1'b1, 1'b0, 1);
        check("hold_redirect_inst_pc", s_inst_pc, 64'h0000_0000_8000_0100);
        cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1);
        check("hold_redirect_addr", s_addr, 64'h0000_0000_8000_0200);

        // PC wrap at the top of the address space
        cycle(1'b0, 64'h0, 1'b1, 1'b1, 1);
        check("top_req_addr", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1);
        cycle(1'b0, 64'h0, 1'b1, 1'b0, 1);
        check("top_inst_pc", s_inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(1'b1, 64'h0000_0000_8000_0002, 1'b1, 1'b0, 1);
        check("wrap_req_addr", s_addr, 64'h0);

        // misaligned target
`ifdef IFU_MISALIGN_TRAP_EN
        cycle(1'b0, 64'h0, 1'b0, 1'b1, 1);
        check("misalign_no_req", 64'(s_req_valid), 64'h0);
        cycle(1'b1, 64'h0000_0000_8000_0400, 1'b0, 1'b0, 1);
        check("misalign_valid", 64'(s_inst_valid), 64'h1);
        check("misalign_fault", 64'(s_fault), 64'h1);
        check("misalign_inst_pc", s_inst_pc, 64'h0000_0000_8000_0002);
        check("misalign_inst", 64'(s_inst), 64'h0);
`else
        cycle(1'b1, 64'h0000_0000_8000_0400, 1'b0, 1'b0, 1);
        check("misalign_req_valid", 64'(s_req_valid), 64'h1);
        check("misalign_req_addr", s_addr, 64'h0000_0000_8000_0002);
`endif

        // randomized traffic with one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) mid_reset();
            rv = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 15))
                0:       rpc = 64'hFFFF_FFFF_FFFF_FFF8;
                1, 2:    rpc = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
                default: rpc = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFC)};
            endcase
            ir = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 2) != 0);
            cycle(rv, rpc, ir, rr, int'($urandom_range(1, 4)));
        end
        check("progress", 64'(consumed >= 100), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
